// File: rtl/psum_fifo_ctrl_pkg.sv
// Shared types and helpers for the partial-sum FIFO controller.
package conv_ctrl_pkg;

    // Controller phases: prefill, steady-state delay line, flush, frame-end pulse.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } psum_state_t;

    // Bits needed to hold the values 0..n inclusive (at least 1).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/psum_fifo_ctrl_wrap_cnt.sv
// Modulo-MOD counter with synchronous clear, enable and carry-out on wrap.
module wrap_cnt
    import conv_ctrl_pkg::*;
#(
    parameter int unsigned MOD = 8,
    parameter int unsigned W   = $clog2(MOD)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         carry
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    assign carry = en && (cnt == LAST);

    // Count enabled cycles, wrapping to zero after MOD-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= carry ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/psum_fifo_ctrl.sv
// Drives a SYNCH_FIFO's strobes so it behaves as a fixed DELAY-sample delay line,
// tags delayed samples with row/col, drains at frame end, flags illegal accesses.
module psum_fifo_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 64,
    parameter int unsigned DEPTH = 61,
    parameter int unsigned DELAY = 60
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     fifo_empty,
    input  logic                     fifo_full,
    output logic                     fifo_wr_en,
    output logic                     fifo_rd_en,
    output logic                     out_valid,
    output logic [$clog2(IMG_W)-1:0] out_col,
    output logic [$clog2(IMG_H)-1:0] out_row,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     proto_err
);

    localparam int unsigned TOTAL = IMG_W * IMG_H;
    localparam int unsigned CW    = cnt_width(TOTAL);
    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);

    localparam logic [CW-1:0] DELAY_C = CW'(DELAY);
    localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);
    localparam logic [CW-1:0] OUT_N_C = CW'(TOTAL - DELAY);

    psum_state_t   state, state_nxt;
    logic [CW-1:0] acc_cnt;
    logic [CW-1:0] acc_inc;
    logic [CW-1:0] out_idx;
    logic          xfer;
    logic          frame_clr;
    logic          col_carry;
    logic          row_carry;

    assign xfer      = in_valid && in_ready;
    assign acc_inc   = acc_cnt + 1'b1;
    assign frame_clr = (state == ST_IDLE) && start;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: phase changes are triggered by the transfer that reaches the boundary.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (start) state_nxt = ST_FILL;
            ST_FILL:   if (xfer && (acc_inc == DELAY_C)) state_nxt = ST_STREAM;
            ST_STREAM: if (xfer && (acc_inc == TOTAL_C)) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (fifo_empty) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Outputs: strobes are combinational so the FIFO write lands on the accepting edge.
    always_comb begin
        in_ready   = 1'b0;
        fifo_wr_en = 1'b0;
        fifo_rd_en = 1'b0;
        busy       = (state != ST_IDLE);
        frame_done = 1'b0;
        unique case (state)
            ST_FILL: begin
                in_ready   = 1'b1;
                fifo_wr_en = in_valid;
            end
            ST_STREAM: begin
                in_ready   = 1'b1;
                fifo_wr_en = in_valid;
                fifo_rd_en = in_valid;
            end
            ST_DRAIN: fifo_rd_en = !fifo_empty;
            ST_DONE:  frame_done = 1'b1;
            default: ;
        endcase
    end

    // Accepted-sample counter for the current frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_cnt <= '0;
        end else if (frame_clr) begin
            acc_cnt <= '0;
        end else if (xfer) begin
            acc_cnt <= acc_inc;
        end
    end

    // out_valid follows a STREAM read by one cycle, matching the FIFO's registered data_out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state == ST_STREAM) && fifo_rd_en;
        end
    end

    // Linear index of the sample currently presented on out_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_idx <= '0;
        end else if (frame_clr) begin
            out_idx <= '0;
        end else if (out_valid) begin
            out_idx <= out_idx + 1'b1;
        end
    end

    // Sticky protocol error: write while full or read while empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            proto_err <= 1'b0;
        end else if ((fifo_wr_en && fifo_full) || (fifo_rd_en && fifo_empty)) begin
            proto_err <= 1'b1;
        end
    end

    // Tags advance after each presented sample, so they describe out_idx while out_valid is high.
    wrap_cnt #(.MOD(IMG_W), .W(COL_W)) u_col_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (frame_clr),
        .en    (out_valid),
        .cnt   (out_col),
        .carry (col_carry)
    );

    wrap_cnt #(.MOD(IMG_H), .W(ROW_W)) u_row_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (frame_clr),
        .en    (col_carry),
        .cnt   (out_row),
        .carry (row_carry)
    );

    // Tagging never runs past the last output of a frame.
    a_idx_range: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid |-> (out_idx < OUT_N_C));
    a_no_row_wrap: assert property (@(posedge clk) disable iff (!rst_n)
        !row_carry);

endmodule

// File: tb/tb_psum_fifo_ctrl.sv
// Scoreboard bench for psum_fifo_ctrl with a behavioural SYNCH_FIFO model.
module tb_psum_fifo_ctrl;

    localparam int IMG_W = 8;
    localparam int IMG_H = 4;
    localparam int DEPTH = 6;
    localparam int DELAY = 5;
    localparam int NPIX  = IMG_W * IMG_H;

    logic       clk = 1'b0;
    logic       rst_n, start, in_valid, in_ready;
    logic       fifo_empty, fifo_full, fifo_wr_en, fifo_rd_en;
    logic       out_valid, busy, frame_done, proto_err;
    logic [2:0] out_col;
    logic [1:0] out_row;
    logic [7:0] din, fifo_dout;
    logic       force_full;

    always #5 clk = ~clk;

    psum_fifo_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DEPTH(DEPTH), .DELAY(DELAY)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_rd_en (fifo_rd_en),
        .out_valid  (out_valid),
        .out_col    (out_col),
        .out_row    (out_row),
        .busy       (busy),
        .frame_done (frame_done),
        .proto_err  (proto_err)
    );

    // FIFO model: registered data_out, occupancy holds on simultaneous read+write.
    logic [7:0] mem [DEPTH];
    int wp = 0, rp = 0, occ = 0;
    assign fifo_empty = (occ == 0);
    assign fifo_full  = force_full || (occ == DEPTH);

    always @(posedge clk) begin
        if (!rst_n) begin
            wp <= 0; rp <= 0; occ <= 0; fifo_dout <= '0;
        end else begin
            if (fifo_wr_en && !fifo_full) begin
                mem[wp] <= din;
                wp <= (wp + 1) % DEPTH;
            end
            if (fifo_rd_en && !fifo_empty) begin
                fifo_dout <= mem[rp];
                rp <= (rp + 1) % DEPTH;
            end
            if (fifo_wr_en && !fifo_rd_en && !fifo_full) occ <= occ + 1;
            else if (fifo_rd_en && !fifo_wr_en && !fifo_empty) occ <= occ - 1;
        end
    end

    int checks = 0, errors = 0;
    int ov_cnt = 0, done_cnt = 0, drain_cnt = 0;
    int kk = 0;

    typedef struct {int data; int row; int col;} exp_t;
    exp_t sbq[$];

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on out_valid, counts drains and frame_done.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                ov_cnt++;
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("data", int'(fifo_dout), e.data);
                    chk("row", int'(out_row), e.row);
                    chk("col", int'(out_col), e.col);
                end
            end
            if (frame_done) done_cnt++;
            if (busy && !in_ready && !frame_done && fifo_rd_en) drain_cnt++;
        end
    end

    task automatic start_frame();
        @(negedge clk);
        start = 1'b1; in_valid = 1'b1; din = 8'hEE;
        #1;
        chk("done_pulse", int'(frame_done), 0);
        chk("idle_ready", int'(in_ready), 0);
        chk("idle_wr", int'(fifo_wr_en), 0);
        chk("idle_busy", int'(busy), 0);
        kk = 0;
    endtask

    task automatic feed_to(input int target, input bit gap, input bit start_mid);
        int cyc = 0;
        while (kk < target && cyc < 400) begin
            @(negedge clk);
            start    = start_mid && (kk == 15);
            in_valid = !gap || (cyc % 2 == 0);
            din      = 8'(kk);
            #1;
            cyc++;
            if (in_valid) chk("ready", int'(in_ready), 1);
            if (in_valid && in_ready) begin
                chk("wr", int'(fifo_wr_en), 1);
                chk("rd", int'(fifo_rd_en), int'(kk >= DELAY));
                if (kk >= DELAY)
                    sbq.push_back('{kk - DELAY, (kk - DELAY) / IMG_W, (kk - DELAY) % IMG_W});
                kk++;
            end else begin
                chk("gap_wr", int'(fifo_wr_en), 0);
                chk("gap_rd", int'(fifo_rd_en), 0);
            end
        end
        chk("feed_timeout", kk, target);
    endtask

    task automatic run_frame(input bit gap, input bit start_mid);
        int ov0, dr0, dn0, cyc;
        start_frame();
        ov0 = ov_cnt; dr0 = drain_cnt; dn0 = done_cnt;
        feed_to(NPIX, gap, start_mid);
        @(negedge clk);
        in_valid = 1'b0; start = 1'b0;
        cyc = 0;
        while (!frame_done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("frame_done", int'(frame_done), 1);
        chk("out_count", ov_cnt - ov0, NPIX - DELAY);
        chk("drain_count", drain_cnt - dr0, DELAY);
        chk("done_count", done_cnt - dn0, 1);
        chk("sb_left", sbq.size(), 0);
        chk("proto_clean", int'(proto_err), 0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_ov"}, int'(out_valid), 0);
        chk({tag, "_done"}, int'(frame_done), 0);
        chk({tag, "_perr"}, int'(proto_err), 0);
        chk({tag, "_rdy"}, int'(in_ready), 0);
        chk({tag, "_wr"}, int'(fifo_wr_en), 0);
        chk({tag, "_rd"}, int'(fifo_rd_en), 0);
        chk({tag, "_col"}, int'(out_col), 0);
        chk({tag, "_row"}, int'(out_row), 0);
    endtask

    initial begin
        int dn0;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; din = '0; force_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back frame with start pulsed during STREAM.
        run_frame(1'b0, 1'b1);
        // Gapped frame, started the cycle after the previous frame_done.
        run_frame(1'b1, 1'b0);
        // Another immediate frame: tags must restart at (0,0).
        run_frame(1'b0, 1'b0);

        // Reset mid-frame after sample 12.
        start_frame();
        feed_to(13, 1'b0, 1'b0);
        dn0 = done_cnt;
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_idle("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        sbq.delete();
        repeat (3) @(negedge clk);
        chk("midrst_no_done", done_cnt - dn0, 0);
        run_frame(1'b0, 1'b0);

        // Write while FIFO reports full during STREAM.
        start_frame();
        feed_to(10, 1'b0, 1'b0);
        @(negedge clk);
        force_full = 1'b1; in_valid = 1'b1; din = 8'(kk);
        #1;
        chk("perr_ready", int'(in_ready), 1);
        chk("perr_wr", int'(fifo_wr_en), 1);
        sbq.push_back('{kk - DELAY, (kk - DELAY) / IMG_W, (kk - DELAY) % IMG_W});
        @(posedge clk);
        #1;
        chk("perr_set", int'(proto_err), 1);
        @(negedge clk);
        force_full = 1'b0; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("perr_sticky", int'(proto_err), 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("perr_cleared", int'(proto_err), 0);
        chk("perr_sb_left", sbq.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        sbq.delete();

        // A clean frame after the error recovery.
        run_frame(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
